// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the MEM stage request port. One word or byte access
// is accepted at a time, held for LATENCY cycles, and completed with a
// single-cycle mem_resp pulse. Reads return the whole 16-bit word; writes
// commit only the enabled byte lanes into an internal word-organized array.
//
// Parameters:
//   ADDR_W       byte-address width
//   DEPTH_WORDS  array depth in 16-bit words (power of two, >= 2)
//   LATENCY      cycles from acceptance to mem_resp (1..15)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem2_read         read request, held until mem_resp
//   mem2_write        write request, held until mem_resp (wins over read)
//   mem_byte_enable   2'b11 word, 2'b01 low byte, 2'b10 high byte
//   mem_address       byte address (aliases modulo 2*DEPTH_WORDS)
//   mem_wdata         write data in lane position
//   mem_rdata         read data, valid only while mem_resp = 1
//   mem_resp          one-cycle completion pulse
//   mem_stall         request present and not completing this cycle
//   mem_err           misaligned word access flag (DMEM_ERRCHK_EN only)
//   dbg_state         current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: the requester raises mem2_read/mem2_write and holds it; the
// request is accepted in the IDLE cycle it is first seen, later changes are
// ignored, and the access is done in the single cycle mem_resp = 1. The
// requester drops or changes its request in the cycle after mem_resp.
//
// Optional feature macro: DMEM_ERRCHK_EN (misaligned word access detection).
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem2_read,
  input  logic              mem2_write,
  input  logic [1:0]        mem_byte_enable,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_resp,
  output logic              mem_stall,
`ifdef DMEM_ERRCHK_EN
  output logic              mem_err,
`endif
  output logic [1:0]        dbg_state
);

  localparam int       IDX_W  = $clog2(DEPTH_WORDS);
  localparam bit [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       be_q, be_d;
  logic             is_write_q, is_write_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             bad_word;
  logic             commit_en;

  // Storage is deliberately outside the reset domain: reset never alters it.
  logic [15:0] mem_array_q [DEPTH_WORDS];

  // Upper address bits alias away and bit 0 never indexes the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[ADDR_W-1:IDX_W+1], mem_address[0]};

`ifdef DMEM_ERRCHK_EN
  logic odd_q, odd_d;
  assign bad_word = (be_q == 2'b11) && odd_q;
`else
  assign bad_word = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state / request latch
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_write_d = is_write_q;
`ifdef DMEM_ERRCHK_EN
    odd_d      = odd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem2_read || mem2_write) begin
          idx_d      = mem_address[IDX_W:1];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
          // A simultaneous read+write is a write; the read is dropped.
          is_write_d = mem2_write;
`ifdef DMEM_ERRCHK_EN
          odd_d      = mem_address[0];
`endif
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The array is read on the edge entering RESP, using the index that is
  // being latched (idx_d), so LATENCY == 1 also sees the right word. Any
  // previous write has already committed on the edge that ended its RESP.
  always_comb begin
    rdata_d = rdata_q;
    if (state_d == ST_RESP) begin
      rdata_d = mem_array_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      be_q       <= 2'b00;
      is_write_q <= 1'b0;
      rdata_q    <= 16'h0000;
`ifdef DMEM_ERRCHK_EN
      odd_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
`ifdef DMEM_ERRCHK_EN
      odd_q      <= odd_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Write commit on the edge ending RESP. A reset mid-access forces IDLE, so
  // a pending write can never reach this point.
  // -------------------------------------------------------------------------
  assign commit_en = (state_q == ST_RESP) && is_write_q && !bad_word;

  always_ff @(posedge clk) begin
    if (commit_en) begin
      if (be_q[0]) mem_array_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_array_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_resp  = (state_q == ST_RESP);
  assign mem_rdata = (mem_resp && !bad_word) ? rdata_q : 16'h0000;
  assign mem_stall = (mem2_read | mem2_write) & ~mem_resp;
  assign dbg_state = state_q;
`ifdef DMEM_ERRCHK_EN
  assign mem_err   = mem_resp && bad_word;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed testbench for dmem_responder (LATENCY = 2, 256 words). Inputs are
// driven on the falling edge; outputs are sampled 1 ns after a falling edge.
// Each access_op call drives a request at a falling edge (acceptance cycle),
// then watches for mem_resp, reporting latency in cycles, the number of
// sampled cycles with mem_stall high, and the read data / error seen in the
// response cycle.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        mem2_read;
  logic        mem2_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_stall;
  logic [1:0]  dbg_state;
`ifdef DMEM_ERRCHK_EN
  logic        mem_err;
`endif

  int checks;
  int errors;

  dmem_responder #(
    .ADDR_W      (16),
    .DEPTH_WORDS (256),
    .LATENCY     (LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem2_read       (mem2_read),
    .mem2_write      (mem2_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .mem_stall       (mem_stall),
`ifdef DMEM_ERRCHK_EN
    .mem_err         (mem_err),
`endif
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic access_op(input logic rd, input logic wr, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input logic alt_en, input logic [15:0] alt_addr,
                           output logic [15:0] rdata, output int lat,
                           output int stall_n, output logic err);
    logic done;
    @(negedge clk);
    mem2_read       = rd;
    mem2_write      = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wd;
    #1;
    lat = -1; stall_n = 0; rdata = 16'h0000; err = 1'b0; done = 1'b0;
    for (int k = 0; k <= 20 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      // Disturb the address while the access is in flight.
      if (k == 1 && alt_en) begin
        mem_address = alt_addr;
        #1;
      end
      if (mem_resp) begin
        lat   = k;
        rdata = mem_rdata;
`ifdef DMEM_ERRCHK_EN
        err   = mem_err;
`endif
        done  = 1'b1;
      end else if (mem_stall) begin
        stall_n++;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem2_read  = 1'b0;
    mem2_write = 1'b0;
  endtask

  task automatic wr_word(input logic [15:0] addr, input logic [15:0] wd);
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    access_op(1'b0, 1'b1, 2'b11, addr, wd, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    mem2_read = 1'b0; mem2_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b exp 0", mem_resp); end
    checks++;
    if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", mem_rdata); end
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b exp 0", mem_stall); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
`ifdef DMEM_ERRCHK_EN
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mem_err); end
`endif
    mem2_read = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_comb got %b exp 1", mem_stall); end
    mem2_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    access_op(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    checks++;
    if (lat_v !== LAT) begin errors++; $display("FAIL basic_wr_latency got %0d exp %0d", lat_v, LAT); end
    checks++;
    if (st_v !== 2) begin errors++; $display("FAIL basic_wr_stall got %0d exp 2", st_v); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    checks++;
    if (lat_v !== LAT) begin errors++; $display("FAIL basic_rd_latency got %0d exp %0d", lat_v, LAT); end
    checks++;
    if (st_v !== 2) begin errors++; $display("FAIL basic_rd_stall got %0d exp 2", st_v); end
    checks++;
    if (rd_v !== 16'hBEEF) begin errors++; $display("FAIL basic_rdata got %h exp beef", rd_v); end
    go_idle();
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL basic_resp_one_cycle got %b exp 0", mem_resp); end
  endtask

  task automatic test_alias();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    // 0x0211 aliases word index 8 (byte 0x0010) of a 512-byte space.
    access_op(1'b1, 1'b0, 2'b01, 16'h0211, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'hBEEF) begin errors++; $display("FAIL alias_rdata got %h exp beef", rd_v); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    wr_word(16'h0020, 16'h1234);
    access_op(1'b0, 1'b1, 2'b01, 16'h0020, 16'hFFAB, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    access_op(1'b0, 1'b1, 2'b10, 16'h0021, 16'hCD55, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    access_op(1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'hCDAB) begin errors++; $display("FAIL byte_lanes got %h exp cdab", rd_v); end
    // Enable 00 write completes but changes nothing.
    access_op(1'b0, 1'b1, 2'b00, 16'h0020, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (lat_v !== LAT) begin errors++; $display("FAIL be00_latency got %0d exp %0d", lat_v, LAT); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'hCDAB) begin errors++; $display("FAIL be00_nochange got %h exp cdab", rd_v); end
  endtask

  task automatic test_rw_both();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    wr_word(16'h0030, 16'h0303);
    access_op(1'b1, 1'b1, 2'b11, 16'h0030, 16'h5A5A, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h0303) begin errors++; $display("FAIL rw_both_old_data got %h exp 0303", rd_v); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h5A5A) begin errors++; $display("FAIL rw_both_is_write got %h exp 5a5a", rd_v); end
  endtask

  task automatic test_addr_change();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    wr_word(16'h0050, 16'h1111);
    access_op(1'b0, 1'b1, 2'b11, 16'h0040, 16'h7777, 1'b1, 16'h0050, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (lat_v !== LAT) begin errors++; $display("FAIL addr_change_latency got %0d exp %0d", lat_v, LAT); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h7777) begin errors++; $display("FAIL addr_change_target got %h exp 7777", rd_v); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0050, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h1111) begin errors++; $display("FAIL addr_change_other got %h exp 1111", rd_v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    wr_word(16'h0060, 16'h0001);
    @(negedge clk);
    mem2_write = 1'b1; mem2_read = 1'b0; mem_byte_enable = 2'b11;
    mem_address = 16'h0060; mem_wdata = 16'hFFFF;
    @(negedge clk);          // BUSY cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mid_resp0 got %b exp 0", mem_resp); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mid_resp1 got %b exp 0", mem_resp); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_mid_state got %0d exp 0", dbg_state); end
    mem2_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mid_after got %b exp 0", mem_resp); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0060, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h0001) begin errors++; $display("FAIL reset_mid_data got %h exp 0001", rd_v); end
  endtask

  task automatic test_misaligned();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    wr_word(16'h0070, 16'h0000);
    access_op(1'b0, 1'b1, 2'b11, 16'h0071, 16'h9999, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (lat_v !== LAT) begin errors++; $display("FAIL misaligned_latency got %0d exp %0d", lat_v, LAT); end
`ifdef DMEM_ERRCHK_EN
    checks++;
    if (err_v !== 1'b1) begin errors++; $display("FAIL misaligned_err got %b exp 1", err_v); end
    checks++;
    if (rd_v !== 16'h0000) begin errors++; $display("FAIL misaligned_rdata got %h exp 0000", rd_v); end
    access_op(1'b1, 1'b0, 2'b11, 16'h0070, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h0000) begin errors++; $display("FAIL misaligned_nowrite got %h exp 0000", rd_v); end
    checks++;
    if (err_v !== 1'b0) begin errors++; $display("FAIL aligned_err got %b exp 0", err_v); end
`else
    access_op(1'b1, 1'b0, 2'b11, 16'h0070, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    go_idle();
    checks++;
    if (rd_v !== 16'h9999) begin errors++; $display("FAIL odd_word_write got %h exp 9999", rd_v); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd_v; int lat_v; int st_v; logic err_v;
    time t1, t2;
    access_op(1'b0, 1'b1, 2'b11, 16'h0080, 16'h4242, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    t1 = $time;
    access_op(1'b1, 1'b0, 2'b11, 16'h0080, 16'h0000, 1'b0, 16'h0, rd_v, lat_v, st_v, err_v);
    t2 = $time;
    go_idle();
    checks++;
    if ((t2 - t1) !== (LAT + 1) * 10) begin
      errors++; $display("FAIL b2b_spacing got %0t exp %0d", t2 - t1, (LAT + 1) * 10);
    end
    checks++;
    if (rd_v !== 16'h4242) begin errors++; $display("FAIL b2b_raw got %h exp 4242", rd_v); end
  endtask

  // -------------------------------------------------------------------------
  // Sequence + report
  // -------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_alias();
    test_byte_lanes();
    test_rw_both();
    test_addr_change();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
